// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants.
// Frame FSM encoding and serial line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period timer.
// Pulses o_bit_end on the last cycle of each bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign o_bit_end = i_enable && (cnt == LAST);

  // count cycles within a bit, wrapping on the bit-end edge
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (i_enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame controller.
// Serialises start, data LSB-first, parity, stop.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_tx_done
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shifted;
  logic [2:0]           bit_cnt;
  logic                 par;
  logic                 bit_end;
  logic                 last_stop;
  logic                 accept;

  assign shifted   = shreg >> 1;
  assign last_stop = (state == STOP) && bit_end
                   && (bit_cnt == LAST_STOP);
  // a request on the final stop edge chains the
  // next frame with no idle gap on the line
  assign accept    = i_tx_start
                   && ((state == IDLE) || last_stop);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (accept),
    .i_enable  (state != IDLE),
    .o_bit_end (bit_end)
  );

  // frame FSM with registered line, busy and done
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      par       <= 1'b0;
      o_tx      <= LINE_IDLE;
      o_busy    <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      o_tx_done <= 1'b0;
      if (accept) begin
        state     <= START;
        shreg     <= i_tx_data;
        bit_cnt   <= '0;
        par       <= (^i_tx_data) ^ PARITY_ODD;
        o_tx      <= START_LVL;
        o_busy    <= 1'b1;
        o_tx_done <= last_stop;
      end else if (bit_end) begin
        unique case (state)
          START: begin
            state <= DATA;
            o_tx  <= shreg[0];
          end
          DATA: begin
            shreg <= shifted;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY_EN) begin
                state <= PARITY;
                o_tx  <= par;
              end else begin
                state <= STOP;
                o_tx  <= LINE_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              o_tx    <= shifted[0];
            end
          end
          PARITY: begin
            state   <= STOP;
            bit_cnt <= '0;
            o_tx    <= LINE_IDLE;
          end
          STOP: begin
            if (bit_cnt == LAST_STOP) begin
              state     <= IDLE;
              bit_cnt   <= '0;
              o_tx      <= LINE_IDLE;
              o_busy    <= 1'b0;
              o_tx_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            o_tx   <= LINE_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
